reg_write_scheduler: RTL

Owns the single write port of the 15-entry register file and shares it between two requesters: the ALU writeback and the memory-load return. It also sequences a register-file clear, which zeroes registers 0..13 one per cycle. It sits between the execute/memory stages and the register file, and drives the file's write enable, write index, write data and mov flag.

---
 rtl/reg_write_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/reg_write_scheduler.sv
// reg_write_scheduler: owns the single register-file write port. It arbitrates
// between ALU writeback and load return (round-robin on contention) and
// sequences a clear that zeroes registers 0..CLR_LAST, one per cycle.
//
// Handshake: a transfer happens in any cycle where valid=1 and ready=1. A
// requester holds reg/data/mov stable while valid=1 and ready=0. ready is
// combinational from FSM state and arbitration, and is never high for both
// requesters in the same cycle.
module reg_write_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 14,
  parameter int CLR_LAST = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [1:0]        alu_mov,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_reg,
  output logic [DATA_W-1:0] wr_data,
  output logic [1:0]        wr_mov,
  output logic              zero_wr_err,
  output logic              state_dbg
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  // The counter runs one past CLR_LAST: that extra CLEAR cycle is the one in
  // which the final write is visible, so requesters stay blocked through it.
  localparam logic [ADDR_W-1:0] CLR_END  = ADDR_W'(CLR_LAST + 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              pri_mem, pri_mem_nx;  // 1: MEM wins the next tie
  logic              alu_go, mem_go;

  assign clr_busy  = (state == CLEAR);
  assign state_dbg = logic'(state);

  // Next-state, clear counter, arbitration and ready generation.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pri_mem_nx = pri_mem;
    alu_ready  = 1'b0;
    mem_ready  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end else if (alu_valid && (!mem_valid || !pri_mem)) begin
          alu_ready = 1'b1;
        end else if (mem_valid) begin
          mem_ready = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == CLR_END) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rst) begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
    end
    alu_go = alu_valid && alu_ready;
    mem_go = mem_valid && mem_ready;
    if (alu_go) pri_mem_nx = 1'b1;
    if (mem_go) pri_mem_nx = 1'b0;
  end

  // State register and the single write-port output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      pri_mem     <= 1'b0;
      wr_en       <= 1'b0;
      wr_reg      <= '0;
      wr_data     <= '0;
      wr_mov      <= '0;
      clr_done    <= 1'b0;
      zero_wr_err <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pri_mem     <= pri_mem_nx;
      wr_en       <= 1'b0;
      clr_done    <= 1'b0;
      zero_wr_err <= 1'b0;
      if (state == CLEAR) begin
        if (cnt == CLR_END) begin
          clr_done <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_reg  <= cnt;
          wr_data <= '0;
          wr_mov  <= '0;
        end
      end else if (alu_go) begin
        if (alu_reg == ZERO_IDX) begin
          zero_wr_err <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_reg  <= alu_reg;
          wr_data <= alu_data;
          wr_mov  <= alu_mov;
        end
      end else if (mem_go) begin
        if (mem_reg == ZERO_IDX) begin
          zero_wr_err <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_reg  <= mem_reg;
          wr_data <= mem_data;
          wr_mov  <= '0;
        end
      end
    end
  end

endmodule
